// File: rtl/misao_pkg.sv
// Shared definitions for the MISA-O memory responder: bus constants and the
// responder state encoding.
package misao_pkg;

  localparam int   NIBBLE_W = 4;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ACK_R = 3'd2,
    ACK_W = 3'd3,
    LOAD  = 3'd4
  } mem_state_t;

endpackage

// File: rtl/misao_nibble_ram.sv
// Single-port nibble storage: synchronous write, asynchronous read.
// Contents are deliberately never reset so a host preload survives a core reset.
module misao_nibble_ram
  import misao_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [NIBBLE_W-1:0] wdata,
  output logic [NIBBLE_W-1:0] rdata
);

  logic [NIBBLE_W-1:0] mem_array [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
  end

  assign rdata = mem_array[addr];

endmodule

// File: rtl/misao_mem_responder.sv
// Slave end of the MISA-O fetch/load/store bus: serves core reads after
// WAIT_CYCLES wait states, accepts one-cycle stores, and lends the RAM to a host loader.
module misao_mem_responder
  import misao_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         cpu_addr,
  input  logic                cpu_rw,
  input  logic [NIBBLE_W-1:0] cpu_wdata,
  output logic [NIBBLE_W-1:0] cpu_rdata,
  output logic                cpu_en_read,
  output logic                cpu_en_write,
  input  logic                load_en,
  input  logic                load_we,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [NIBBLE_W-1:0] load_data,
  output logic                load_grant
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [3:0]          wait_cnt_reg, wait_cnt_next;
  logic [NIBBLE_W-1:0] cpu_rdata_reg;
  logic                en_read_reg, en_write_reg, load_grant_reg;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [NIBBLE_W-1:0] ram_wdata, ram_rdata;

  // Upper core address bits alias onto the RAM and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr[15:ADDR_W];

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load_en) begin
          state_next = LOAD;
        end else if (cpu_rw == RW_READ) begin
          addr_next     = cpu_addr[ADDR_W-1:0];
          wait_cnt_next = 4'd0;
          state_next    = (WAIT_CYCLES > 0) ? WAIT : ACK_R;
        end else begin
          addr_next  = cpu_addr[ADDR_W-1:0];
          state_next = ACK_W;
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt_reg + 4'd1;
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = ACK_R;
        end
      end
      ACK_R:   state_next = IDLE;
      ACK_W:   state_next = IDLE;
      LOAD: begin
        if (!load_en) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The read port must already point at the target when ACK_R is entered,
  // which for zero wait states is straight from the live core address.
  always_comb begin
    case (state_reg)
      LOAD:    ram_addr = load_addr;
      IDLE:    ram_addr = cpu_addr[ADDR_W-1:0];
      default: ram_addr = addr_reg;
    endcase
  end

  assign ram_we    = (state_reg == ACK_W) || ((state_reg == LOAD) && load_we);
  assign ram_wdata = (state_reg == LOAD) ? load_data : cpu_wdata;

  misao_nibble_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Outputs are registered from the next state so they line up with it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wait_cnt_reg   <= 4'd0;
      cpu_rdata_reg  <= '0;
      en_read_reg    <= 1'b0;
      en_write_reg   <= 1'b0;
      load_grant_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      wait_cnt_reg   <= wait_cnt_next;
      en_read_reg    <= (state_next == ACK_R);
      en_write_reg   <= (state_next == ACK_W);
      load_grant_reg <= (state_next == LOAD);
      if (state_next == ACK_R) begin
        cpu_rdata_reg <= ram_rdata;
      end
    end
  end

  assign cpu_rdata    = cpu_rdata_reg;
  assign cpu_en_read  = en_read_reg;
  assign cpu_en_write = en_write_reg;
  assign load_grant   = load_grant_reg;

endmodule

// File: tb/tb_misao_mem_responder.sv
// Drives two responders (0 and 1 wait states) with shared directed stimulus and
// checks both every cycle against a transaction-level model plus literal expectations.
module tb_misao_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic        cpu_rw = 1'b1;
  logic [3:0]  cpu_wdata = 4'h0;
  logic        load_en = 1'b1;
  logic        load_we = 1'b0;
  logic [7:0]  load_addr = 8'h0;
  logic [3:0]  load_data = 4'h0;

  logic [3:0]  dut_rdata [2];
  logic        dut_er [2];
  logic        dut_ew [2];
  logic        dut_g [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  misao_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
    .cpu_rdata(dut_rdata[0]), .cpu_en_read(dut_er[0]), .cpu_en_write(dut_ew[0]),
    .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_grant(dut_g[0])
  );

  misao_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
    .cpu_rdata(dut_rdata[1]), .cpu_en_read(dut_er[1]), .cpu_en_write(dut_ew[1]),
    .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_grant(dut_g[1])
  );

  function automatic int wc(input int inst);
    return (inst == 0) ? 0 : 1;
  endfunction

  function automatic logic [3:0] pat(input int a);
    case (a)
      0:       return 4'h5;
      1:       return 4'hA;
      2:       return 4'h3;
      3:       return 4'hF;
      default: return 4'((a * 7 + 3) % 16);
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 free, 1 waiting, 2 read ack, 3 write ack, 4 host owns RAM.
  int         m_ph [2];
  int         m_left [2];
  logic [7:0] m_a [2];
  logic [3:0] m_mem [2][256];
  logic [3:0] x_rd [2];
  logic       x_er [2];
  logic       x_ew [2];
  logic       x_g [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_ph[i] <= 0;  m_left[i] <= 0;  m_a[i] <= 8'h0;
        x_rd[i] <= 4'h0;  x_er[i] <= 1'b0;  x_ew[i] <= 1'b0;  x_g[i] <= 1'b0;
      end else begin
        case (m_ph[i])
          0: begin
            if (load_en) begin
              m_ph[i] <= 4;  x_g[i] <= 1'b1;
            end else if (cpu_rw) begin
              m_a[i] <= 8'(cpu_addr % 16'd256);
              if (wc(i) == 0) begin
                m_ph[i] <= 2;  x_er[i] <= 1'b1;
                x_rd[i] <= m_mem[i][cpu_addr % 16'd256];
              end else begin
                m_ph[i] <= 1;  m_left[i] <= wc(i);
              end
            end else begin
              m_a[i] <= 8'(cpu_addr % 16'd256);
              m_ph[i] <= 3;  x_ew[i] <= 1'b1;
            end
          end
          1: begin
            if (m_left[i] == 1) begin
              m_ph[i] <= 2;  x_er[i] <= 1'b1;  x_rd[i] <= m_mem[i][m_a[i]];
            end else begin
              m_left[i] <= m_left[i] - 1;
            end
          end
          2: begin
            m_ph[i] <= 0;  x_er[i] <= 1'b0;
          end
          3: begin
            m_mem[i][m_a[i]] <= cpu_wdata;
            m_ph[i] <= 0;  x_ew[i] <= 1'b0;
          end
          default: begin
            if (load_we) m_mem[i][load_addr] <= load_data;
            if (!load_en) begin
              m_ph[i] <= 0;  x_g[i] <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  logic prev_er0 = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("cpu_en_read", i, int'(dut_er[i]), int'(x_er[i]));
      chk("cpu_en_write", i, int'(dut_ew[i]), int'(x_ew[i]));
      chk("load_grant", i, int'(dut_g[i]), int'(x_g[i]));
      chk("cpu_rdata", i, int'(dut_rdata[i]), int'(x_rd[i]));
    end
    chk("no_back_to_back_read", 0, int'(prev_er0 && dut_er[0]), 0);
    prev_er0 <= dut_er[0];
  end

  task automatic wait_ack(input bit want_write, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      cyc  = k;
      seen = want_write ? dut_ew[1] : dut_er[1];
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout dut1: got no %s ack expected one within 30 cycles",
               want_write ? "write" : "read");
    end
  endtask

  task automatic core_read(input logic [15:0] a, input logic [3:0] exp);
    int cyc;
    cpu_rw   = 1'b1;
    cpu_addr = a;
    wait_ack(1'b0, cyc);
    chk("read_data_literal", 1, int'(dut_rdata[1]), int'(exp));
  endtask

  task automatic core_write(input logic [15:0] a, input logic [3:0] d);
    int cyc;
    cpu_rw    = 1'b0;
    cpu_addr  = a;
    cpu_wdata = d;
    wait_ack(1'b1, cyc);
    cpu_rw = 1'b1;
    @(negedge clk);
    chk("write_single_pulse", 1, int'(dut_ew[1]), 0);
  endtask

  initial begin
    int cyc;
    int pulses;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_en_read", i, int'(dut_er[i]), 0);
      chk("reset_en_write", i, int'(dut_ew[i]), 0);
      chk("reset_rdata", i, int'(dut_rdata[i]), 0);
      chk("reset_grant", i, int'(dut_g[i]), 0);
    end

    // Host preload with load_en already high, so the first IDLE sample enters LOAD.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("grant_rise_literal", 1, int'(dut_g[1]), 1);
    for (int a = 0; a < 256; a++) begin
      load_we   = 1'b1;
      load_addr = 8'(a);
      load_data = pat(a);
      @(negedge clk);
    end
    load_we  = 1'b0;
    load_en  = 1'b0;
    cpu_rw   = 1'b1;
    cpu_addr = 16'h0;
    @(negedge clk);
    chk("grant_fall_literal", 1, int'(dut_g[1]), 0);

    // Reads 0..3 with one wait state: one pulse every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      cpu_addr = 16'(k);
      wait_ack(1'b0, cyc);
      chk("preload_read_literal", 1, int'(dut_rdata[1]), int'(pat(k)));
      if (k > 0) chk("read_period_literal", 1, cyc, 3);
    end

    core_write(16'h0012, 4'h7);
    core_read(16'h0012, 4'h7);
    core_write(16'h0105, 4'h9);
    core_read(16'h0005, 4'h9);

    // Host request arriving during ACK_R: read completes, then LOAD.
    cpu_addr = 16'h0002;
    wait_ack(1'b0, cyc);
    chk("ack_before_load_literal", 1, int'(dut_rdata[1]), 3);
    load_en   = 1'b1;
    load_we   = 1'b1;
    load_addr = 8'h20;
    load_data = 4'hC;
    @(negedge clk);
    chk("grant_low_in_idle", 1, int'(dut_g[1]), 0);
    @(negedge clk);
    chk("grant_high_after_idle", 1, int'(dut_g[1]), 1);
    load_addr = 8'h21;
    load_data = 4'hD;
    @(negedge clk);
    load_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_core_ack_in_load", 1, int'(dut_er[1] || dut_ew[1]), 0);
    end
    load_en = 1'b0;
    @(negedge clk);
    chk("grant_drop_literal", 1, int'(dut_g[1]), 0);
    core_read(16'h0020, pat(32));
    core_read(16'h0021, 4'hD);

    // Reset asserted mid-WAIT.
    cpu_addr = 16'h0001;
    wait_ack(1'b0, cyc);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midwait_reset_en_read", i, int'(dut_er[i]), 0);
      chk("midwait_reset_rdata", i, int'(dut_rdata[i]), 0);
      chk("midwait_reset_grant", i, int'(dut_g[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b0, cyc);
    chk("latency_after_reset", 1, cyc, 2);
    chk("data_after_reset", 1, int'(dut_rdata[1]), 4'hA);

    // Zero wait states, steady reads: exactly every other cycle.
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dut_er[0]) begin
        pulses++;
        chk("w0_read_data_literal", 0, int'(dut_rdata[0]), 4'hA);
      end
    end
    chk("w0_pulse_count", 0, pulses, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
